// File: rtl/icache_loader.sv
// Byte-stream program loader: takes a length header plus big-endian instruction
// bytes over valid/ready and writes assembled 32-bit words into the icache.
module icache_loader #(
    parameter int WORDS = 64,
    parameter int CNT_W = 7
) (
    input  logic             PHI1,
    input  logic             MRST,
    input  logic             Start,
    input  logic [7:0]       RxData,
    input  logic             RxValid,
    output logic             RxReady,
    output logic [31:0]      IAddrE,
    output logic [31:0]      IInE,
    output logic             IWriteE,
    output logic             Busy,
    output logic             LoadDone,
    output logic             LoadErr,
    output logic [CNT_W-1:0] WordCount
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_RECV,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t           state, next_state;
    logic [CNT_W-1:0] n_len;
    logic [1:0]       byte_cnt;
    logic [23:0]      asm_q;
    logic             accept;
    logic [8:0]       hdr_eff;
    logic             hdr_ok;
    logic             last_word;

    assign accept = RxValid & RxReady;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        hdr_eff    = (RxData == 8'd0) ? 9'(WORDS) : {1'b0, RxData};
        hdr_ok     = (hdr_eff <= 9'(WORDS));
        last_word  = ((WordCount + CNT_W'(1)) == n_len);
        next_state = state;
        case (state)
            S_IDLE:  if (Start) next_state = S_HDR;
            S_HDR:   if (accept) next_state = hdr_ok ? S_RECV : S_ERR;
            S_RECV:  if (accept && byte_cnt == 2'd3) next_state = S_WRITE;
            S_WRITE: next_state = last_word ? S_DONE : S_RECV;
            S_DONE:  if (Start) next_state = S_HDR;
            S_ERR:   if (Start) next_state = S_HDR;
            default: next_state = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge PHI1 or negedge MRST) begin
        if (!MRST) begin
            state     <= S_IDLE;
            n_len     <= '0;
            byte_cnt  <= '0;
            asm_q     <= '0;
            WordCount <= '0;
            IAddrE    <= '0;
            IInE      <= '0;
            RxReady   <= 1'b0;
            IWriteE   <= 1'b0;
            Busy      <= 1'b0;
            LoadDone  <= 1'b0;
            LoadErr   <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                S_HDR: begin
                    if (accept && hdr_ok) begin
                        n_len     <= CNT_W'(hdr_eff);
                        byte_cnt  <= '0;
                        WordCount <= '0;
                    end
                end
                S_RECV: begin
                    if (accept) begin
                        asm_q    <= {asm_q[15:0], RxData};
                        byte_cnt <= byte_cnt + 2'd1;
                        // The fourth byte completes the word; capture it for the write cycle.
                        if (byte_cnt == 2'd3) begin
                            IAddrE <= 32'(WordCount);
                            IInE   <= {asm_q, RxData};
                        end
                    end
                end
                S_WRITE: WordCount <= WordCount + CNT_W'(1);
                default: ;
            endcase
            // Status outputs are registered decodes of the state being entered.
            RxReady  <= (next_state == S_HDR) || (next_state == S_RECV);
            IWriteE  <= (next_state == S_WRITE);
            Busy     <= (next_state == S_HDR) || (next_state == S_RECV) || (next_state == S_WRITE);
            LoadDone <= (next_state == S_DONE);
            LoadErr  <= (next_state == S_ERR);
        end
    end

endmodule

// File: tb/tb_icache_loader.sv
// Self-checking bench for icache_loader: directed loads with random data and
// gaps, checked against a byte-list model of the expected cache writes.
module tb_icache_loader;

    localparam int WORDS = 64;
    localparam int CNT_W = 7;

    logic             PHI1 = 1'b0;
    logic             MRST = 1'b0;
    logic             Start = 1'b0;
    logic [7:0]       RxData = 8'h00;
    logic             RxValid = 1'b0;
    logic             RxReady;
    logic [31:0]      IAddrE;
    logic [31:0]      IInE;
    logic             IWriteE;
    logic             Busy;
    logic             LoadDone;
    logic             LoadErr;
    logic [CNT_W-1:0] WordCount;

    icache_loader #(.WORDS(WORDS), .CNT_W(CNT_W)) dut (
        .PHI1(PHI1), .MRST(MRST), .Start(Start), .RxData(RxData), .RxValid(RxValid),
        .RxReady(RxReady), .IAddrE(IAddrE), .IInE(IInE), .IWriteE(IWriteE),
        .Busy(Busy), .LoadDone(LoadDone), .LoadErr(LoadErr), .WordCount(WordCount)
    );

    always #5 PHI1 = ~PHI1;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    logic [7:0]  acc_q[$];
    int          overlap_cnt = 0;

    // Passive monitor: log writes and consumed bytes as the cache/host would see them.
    always @(posedge PHI1) begin
        if (IWriteE) begin
            wr_addr.push_back(IAddrE);
            wr_data.push_back(IInE);
        end
        if (RxValid && RxReady) acc_q.push_back(RxData);
        if (IWriteE && RxValid && RxReady) overlap_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        wr_addr.delete();
        wr_data.delete();
        acc_q.delete();
        overlap_cnt = 0;
    endtask

    task automatic pulse_start();
        @(negedge PHI1);
        RxValid = 1'b0;
        Start   = 1'b1;
        @(negedge PHI1);
        Start   = 1'b0;
    endtask

    // Present one byte, raising RxValid with the given percent duty, until consumed.
    task automatic send_byte(input logic [7:0] b, input int duty);
        bit done = 0;
        for (int w = 0; w < 2000 && !done; w++) begin
            @(negedge PHI1);
            RxData  = b;
            RxValid = ($urandom_range(99) < duty);
            @(posedge PHI1);
            if (RxValid && RxReady) done = 1;
        end
        if (!done) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_end(input string tag);
        int c = 0;
        @(negedge PHI1);
        RxValid = 1'b0;
        while (!(LoadDone || LoadErr) && c < 100) begin
            @(negedge PHI1);
            c++;
        end
        check({tag, "_end_wait"}, {31'd0, LoadDone || LoadErr}, 32'd1);
    endtask

    // Reference model: header rule plus big-endian grouping of the byte list.
    task automatic run_load(input logic [7:0] q[$], input int duty, input string tag);
        int          n;
        logic [31:0] exp_d[$];
        n = (q[0] == 8'd0) ? WORDS : int'(q[0]);
        if (n <= WORDS)
            for (int w = 0; w < n; w++)
                exp_d.push_back({q[1+4*w], q[2+4*w], q[3+4*w], q[4+4*w]});
        pulse_start();
        clear_logs();
        foreach (q[i]) begin
            if (n > WORDS && i > 0) break;
            send_byte(q[i], duty);
        end
        wait_end(tag);
        check({tag, "_nwrites"}, wr_addr.size(), exp_d.size());
        for (int i = 0; i < exp_d.size() && i < wr_addr.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), wr_addr[i], i);
            check($sformatf("%s_data%0d", tag, i), wr_data[i], exp_d[i]);
        end
        check({tag, "_busy"}, {31'd0, Busy}, 32'd0);
        check({tag, "_overlap"}, overlap_cnt, 32'd0);
        if (n <= WORDS) begin
            check({tag, "_done"}, {31'd0, LoadDone}, 32'd1);
            check({tag, "_err"}, {31'd0, LoadErr}, 32'd0);
            check({tag, "_wcount"}, 32'(WordCount), n);
            check({tag, "_nbytes"}, acc_q.size(), q.size());
            for (int i = 0; i < q.size() && i < acc_q.size(); i++)
                check($sformatf("%s_byte%0d", tag, i), 32'(acc_q[i]), 32'(q[i]));
        end else begin
            check({tag, "_done"}, {31'd0, LoadDone}, 32'd0);
            check({tag, "_err"}, {31'd0, LoadErr}, 32'd1);
            check({tag, "_ready"}, {31'd0, RxReady}, 32'd0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, {31'd0, RxReady}, 32'd0);
        check({tag, "_wr"}, {31'd0, IWriteE}, 32'd0);
        check({tag, "_busy"}, {31'd0, Busy}, 32'd0);
        check({tag, "_done"}, {31'd0, LoadDone}, 32'd0);
        check({tag, "_err"}, {31'd0, LoadErr}, 32'd0);
        check({tag, "_addr"}, IAddrE, 32'd0);
        check({tag, "_data"}, IInE, 32'd0);
        check({tag, "_wcount"}, 32'(WordCount), 32'd0);
    endtask

    initial begin
        logic [7:0] q[$];

        // Power-on reset.
        #12;
        check_reset_outputs("por");
        @(negedge PHI1);
        MRST = 1'b1;

        // Random traffic, then an asynchronous reset seen before the next edge.
        pulse_start();
        for (int i = 0; i < 40; i++) begin
            @(negedge PHI1);
            RxData  = 8'($urandom_range(1, 255));
            RxValid = $urandom_range(1);
            Start   = ($urandom_range(15) == 0);
        end
        q = {8'h02};
        @(negedge PHI1);
        #2 MRST = 1'b0;
        #1 check_reset_outputs("rst_mid");
        @(negedge PHI1);
        Start = 1'b0; RxValid = 1'b0; MRST = 1'b1;

        // Two-word load.
        q = {8'h02, 8'h20, 8'h21, 8'h00, 8'h06, 8'hCC, 8'h61, 8'h00, 8'h05};
        run_load(q, 100, "two");

        // Full load with header 00 and index-pattern data.
        q = {8'h00};
        for (int i = 0; i < 4 * WORDS; i++) q.push_back(8'(i));
        run_load(q, 100, "full");
        check("full_last_addr", wr_addr[wr_addr.size()-1], 32'(WORDS - 1));

        // Oversize header, then a normal one-word load clears the error.
        q = {8'h41};
        run_load(q, 100, "over");
        repeat (3) @(negedge PHI1);
        check("over_hold_ready", {31'd0, RxReady}, 32'd0);
        q = {8'h01};
        for (int i = 0; i < 4; i++) q.push_back(8'($urandom));
        run_load(q, 100, "after_err");

        // Backpressure: 30% valid duty over a 3-word load.
        q = {8'h03};
        for (int i = 0; i < 12; i++) q.push_back(8'($urandom));
        run_load(q, 30, "bp");

        // Abort: Start ignored mid-RECV, reset after 6 bytes of a 4-word load.
        q = {8'h04};
        for (int i = 0; i < 16; i++) q.push_back(8'($urandom));
        pulse_start();
        clear_logs();
        for (int i = 0; i < 3; i++) send_byte(q[i], 100);
        pulse_start();
        check("abort_busy_after_start", {31'd0, Busy}, 32'd1);
        for (int i = 3; i < 6; i++) send_byte(q[i], 100);
        repeat (2) @(negedge PHI1);
        RxValid = 1'b0;
        check("abort_nwrites", wr_addr.size(), 32'd1);
        check("abort_word0", wr_data[0], {q[1], q[2], q[3], q[4]});
        #2 MRST = 1'b0;
        #1 check("abort_busy", {31'd0, Busy}, 32'd0);
        check("abort_ready", {31'd0, RxReady}, 32'd0);
        @(negedge PHI1);
        MRST = 1'b1;
        q = {8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run_load(q, 100, "restart");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
